// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: MAX_PORTS, default RAM geometry, port index width helper,
// muxed RAM request struct and per-port response struct.
package sp_ram_arb_pkg;

    localparam int MAX_PORTS  = 4;
    localparam int RAM_ADDR_W = 15;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_BE_W   = RAM_DATA_W / 8;

    // Width of a port index; never below 1 so a 1-bit register still exists.
    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic                  we;
        logic [RAM_BE_W-1:0]   be;
        logic [RAM_DATA_W-1:0] wdata;
    } ram_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic [RAM_DATA_W-1:0] rdata;
    } ram_rsp_t;

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Requester-side and RAM-side signal bundle of the RAM arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/addr/we/be/wdata until gnt.
//
// Requester side: req_i, addr_i, we_i, be_i, wdata_i (packed, port p at slice p),
//                 gnt_o, rvalid_o, rdata_o.
// RAM side:       ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, ram_rdata_i.
// Modports: slave = arbiter view, master = requesters + RAM wrapper view.
interface sp_ram_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_PORTS-1:0]            we_i;
    logic [NUM_PORTS*BE_WIDTH-1:0]   be_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS-1:0]            gnt_o;
    logic [NUM_PORTS-1:0]            rvalid_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o;

    logic                            ram_en_o;
    logic [ADDR_WIDTH-1:0]           ram_addr_o;
    logic                            ram_we_o;
    logic [BE_WIDTH-1:0]             ram_be_o;
    logic [DATA_WIDTH-1:0]           ram_wdata_o;
    logic [DATA_WIDTH-1:0]           ram_rdata_i;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, ram_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
        output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, ram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
        input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
    );

endinterface

// File: rtl/sp_ram_arbiter_rr_arb.sv
// Round-robin arbiter: one-hot grant plus index, owns the last-winner register.
// Latency: grant is combinational in the request cycle.
// Backpressure: losers simply see no grant and keep requesting.
//
// Ports: clk, rst_i (sync, active-high), i_req (per-port request),
//        o_gnt (one-hot or zero), o_idx (granted index, 0 when no grant).
module sp_ram_rr_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = port_idx_w(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_gnt,
    output logic [IDX_W-1:0]     o_idx
);

    logic [IDX_W-1:0] r_last;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Scan ports starting just after the last winner, wrapping around.
    // One extra bit in w_sum holds last+k before the modulo fold.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_PORTS)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_PORTS);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

    // Reset to the highest index so port 0 is first in line afterwards.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_last <= IDX_W'(NUM_PORTS - 1);
        end else if (|i_req) begin
            r_last <= o_idx;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM among NUM_PORTS requesters with round-robin arbitration.
// Latency: grant same cycle as request; rvalid/rdata one cycle after grant.
// Backpressure: a request waits (no gnt) until it wins; one access per cycle.
//
// Ports: clk, rst_i (sync, active-high), bus (sp_ram_arbiter_if.slave) carrying
//        per-port req/addr/we/be/wdata/gnt/rvalid/rdata and the RAM-side ram_* signals.
// Optional macro SP_RAM_ARB_RDATA_HOLD_EN: per-port registers keep the last read
// data on rdata_o until that port's next response.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = RAM_ADDR_W,
    parameter int DATA_WIDTH = RAM_DATA_W
) (
    input  logic             clk,
    input  logic             rst_i,
    sp_ram_arbiter_if.slave  bus
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = port_idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0] w_gnt;
    logic [IDX_W-1:0]     w_idx;
    ram_req_t             w_sel;
    logic [NUM_PORTS-1:0] w_rvalid;
    ram_rsp_t             w_rsp [NUM_PORTS];

    logic                 r_resp_vld;
    logic [IDX_W-1:0]     r_resp_idx;
    logic                 r_resp_rd;

    sp_ram_rr_arb #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_arb (
        .clk   (clk),
        .rst_i (rst_i),
        .i_req (bus.req_i),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // Request mux; everything reads as zero when nobody is granted.
    always_comb begin
        w_sel = '0;
        if (|w_gnt) begin
            w_sel.addr  = bus.addr_i [w_idx*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel.we    = bus.we_i   [w_idx];
            w_sel.be    = bus.be_i   [w_idx*BE_W +: BE_W];
            w_sel.wdata = bus.wdata_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.gnt_o       = w_gnt;
    assign bus.ram_en_o    = |bus.req_i;
    assign bus.ram_addr_o  = w_sel.addr;
    assign bus.ram_we_o    = w_sel.we;
    assign bus.ram_be_o    = w_sel.be;
    assign bus.ram_wdata_o = w_sel.wdata;

    // Response pipeline tracks who owns the data coming back next cycle.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_resp_vld <= 1'b0;
            r_resp_idx <= '0;
            r_resp_rd  <= 1'b0;
        end else begin
            r_resp_vld <= |w_gnt;
            r_resp_idx <= w_idx;
            r_resp_rd  <= ~w_sel.we;
        end
    end

    // Gating with rst_i drops a response whose grant preceded a reset cycle.
    always_comb begin
        w_rvalid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rvalid[p] = r_resp_vld && !rst_i && (r_resp_idx == IDX_W'(p));
        end
    end

`ifdef SP_RAM_ARB_RDATA_HOLD_EN
    logic [DATA_WIDTH-1:0] r_hold [NUM_PORTS];

    // Only read responses refresh a port's held data.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_hold[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_rvalid[p] && r_resp_rd) begin
                    r_hold[p] <= bus.ram_rdata_i;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rsp[p].rvalid = w_rvalid[p];
            w_rsp[p].rdata  = w_rvalid[p] ? bus.ram_rdata_i : r_hold[p];
        end
    end
`else
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rsp[p].rvalid = w_rvalid[p];
            w_rsp[p].rdata  = bus.ram_rdata_i;
        end
    end
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        assign bus.rvalid_o[p]                          = w_rsp[p].rvalid;
        assign bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = w_rsp[p].rdata;
    end

endmodule
